// File: rtl/fetch_pkg.sv
// ==== fetch_pkg : shared types and constants for the fetch queue ===== rev 1.0 ====
`default_nettype none

package fetch_pkg;

    localparam logic [3:0]  WIDTH_WORD       = 4'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSN_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ==== fetch_fifo : DEPTH-entry {pc,data} FIFO, flush beats push/pop ==== rev 1.0 ====
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ==== fetch_queue : sequential instruction fetch with redirect and output FIFO ====
// ==== optional combinational bypass of an empty FIFO: FETCH_BYPASS_EN ==== rev 1.0 ====
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pm_address,
    output logic [3:0]  pm_width,
    output logic        pm_req,
    input  logic [31:0] pm_data_in,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;

    fetch_entry_t fifo_head;
    fetch_entry_t fifo_entry;
    logic [CW-1:0] fifo_count;
    logic         fifo_push;
    logic         fifo_pop;
    logic         bypass;
    logic         deq;
    logic [CW:0]  occupancy;

    always_comb begin
        pm_width   = WIDTH_WORD;
        pm_address = redirect_valid ? word_align(redirect_pc) : pc_q;

`ifdef FETCH_BYPASS_EN
        bypass = (fifo_count == '0) && inflight_q && !redirect_valid;
`else
        bypass = 1'b0;
`endif

        inst_valid = (fifo_count != '0) || bypass;
        inst_data  = bypass ? pm_data_in  : fifo_head.data;
        inst_pc    = bypass ? inflight_pc_q : fifo_head.pc;

        // A redirect flushes the queue, so a coincident handshake never counts.
        deq       = inst_valid && inst_ready && !redirect_valid;
        fifo_pop  = deq && !bypass;
        fifo_push = inflight_q && !redirect_valid && !(bypass && inst_ready);
        fifo_entry = '{pc: inflight_pc_q, data: pm_data_in};

        // Only issue when the returning word is guaranteed a free slot.
        occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(deq);
        pm_req    = !reset && (redirect_valid || (occupancy < (CW+1)'(DEPTH)));

        inflight_d    = pm_req;
        inflight_pc_d = pm_req ? pm_address : inflight_pc_q;
        pc_d          = pm_req ? (pm_address + 32'd4) : pc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q          <= word_align(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (fifo_push),
        .push_entry (fifo_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ==== tb_fetch_queue : directed + random bench for fetch_queue ==== rev 1.0 ====
`default_nettype none

module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic [31:0] pm_address;
    logic [3:0]  pm_width;
    logic        pm_req;
    logic [31:0] pm_data_in = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        reset2 = 1'b1;
    logic [31:0] pm2_address;
    logic [3:0]  pm2_width;
    logic        pm2_req;
    logic [31:0] pm2_data_in = '0;
    logic        inst2_valid;
    logic        inst2_ready = 1'b1;
    logic [31:0] inst2_data;
    logic [31:0] inst2_pc;
    logic        redirect2_valid = 1'b0;
    logic [31:0] redirect2_pc = '0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .pm_address(pm_address), .pm_width(pm_width), .pm_req(pm_req), .pm_data_in(pm_data_in),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clock(clock), .reset(reset2),
        .pm_address(pm2_address), .pm_width(pm2_width), .pm_req(pm2_req), .pm_data_in(pm2_data_in),
        .inst_valid(inst2_valid), .inst_ready(inst2_ready), .inst_data(inst2_data), .inst_pc(inst2_pc),
        .redirect_valid(redirect2_valid), .redirect_pc(redirect2_pc)
    );

    // Program memory contents as a pure function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a < 32'h10) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clock) if (pm_req)  pm_data_in  <= memf(pm_address);
    always @(posedge clock) if (pm2_req) pm2_data_in <= memf(pm2_address);

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the delivered stream is target, target+4, ... since the last restart.
    logic [31:0] exp_pc = '0;
    logic [31:0] tgt = '0;
    int          since = -1;
    logic        restart = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        vectors++;
        chk("pm_width", 32'(pm_width), 32'd4);
        chk("pm_addr_align", 32'(pm_address[1:0]), 32'd0);
        chk("count_le_depth", 32'(dut.fifo_count <= DEPTH), 32'd1);
        if (prev_hold) begin
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_pc", inst_pc, prev_pc);
            chk("hold_data", inst_data, prev_data);
        end
        if (since >= 0) begin
            since++;
`ifndef FETCH_BYPASS_EN
            if (since == 1) chk("restart_bubble", 32'(inst_valid), 32'd0);
`endif
            if (since == LAT) begin
                chk("restart_valid", 32'(inst_valid), 32'd1);
                chk("restart_pc", inst_pc, tgt);
                since = -1;
            end
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            chk("deq_pc", inst_pc, exp_pc);
            chk("deq_data", inst_data, memf(exp_pc));
            exp_pc += 32'd4;
        end
        if (restart) begin
            chk("restart_req", 32'(pm_req), 32'd1);
            chk("restart_addr", pm_address, 32'h0);
            exp_pc = 32'h0; tgt = 32'h0; since = 0; restart = 1'b0;
        end
        if (redirect_valid) begin
            chk("redir_req", 32'(pm_req), 32'd1);
            chk("redir_addr", pm_address, redirect_pc & ~32'd3);
            exp_pc = redirect_pc & ~32'd3; tgt = exp_pc; since = 0;
        end
        prev_hold = inst_valid && !inst_ready && !redirect_valid;
        prev_pc   = inst_pc;
        prev_data = inst_data;
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        check_cycle();
        @(negedge clock);
    endtask

    task automatic do_reset();
        inst_ready = 1'b0; redirect_valid = 1'b0; reset = 1'b1;
        #1;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req", 32'(pm_req), 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_count", 32'(dut.fifo_count), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0; restart = 1'b1; since = -1; prev_hold = 1'b0;
    endtask

    initial begin
        logic [31:0] e2;
        logic        rdy, rv;
        logic [31:0] rpc;

        @(negedge clock);
        do_reset();
        repeat (8) step(1'b1, 1'b0, '0);

        // Backpressure: queue fills, issue stops, head is the first word.
        do_reset();
        repeat (9) step(1'b0, 1'b0, '0);
        inst_ready = 1'b0; #1;
        chk("bp_count", 32'(dut.fifo_count), 32'd4);
        chk("bp_req", 32'(pm_req), 32'd0);
        chk("bp_head_pc", inst_pc, 32'h0);
        chk("bp_head_data", inst_data, 32'h11);
        check_cycle();
        @(negedge clock);
        repeat (8) step(1'b1, 1'b0, '0);

        // Redirect with three buffered entries and one in flight.
        do_reset();
        repeat (4) step(1'b0, 1'b0, '0);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("pre_redir_count", 32'(dut.fifo_count), 32'd3);
        chk("pre_redir_inflight", 32'(dut.inflight_q), 32'd1);
        check_cycle();
        @(negedge clock);
        repeat (6) step(1'b1, 1'b0, '0);

        // Redirect concurrent with a handshake, then a back-to-back redirect.
        step(1'b1, 1'b1, 32'h80);
        step(1'b1, 1'b1, 32'h102);
        repeat (6) step(1'b1, 1'b0, '0);

        // Random traffic, with targets often close to the address wrap.
        repeat (400) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            step(rdy, rv, rpc);
        end

        // Reset mid-stream with three entries buffered.
        do_reset();
        repeat (4) step(1'b0, 1'b0, '0);
        chk("mid_count", 32'(dut.fifo_count), 32'd3);
        do_reset();
        repeat (6) step(1'b1, 1'b0, '0);

        // Non-zero reset PC that wraps through zero.
        e2 = 32'hFFFF_FFF8;
        inst_ready = 1'b0;
        reset2 = 1'b0;
        repeat (8) begin
            #1;
            chk("wrap_width", 32'(pm2_width), 32'd4);
            if (inst2_valid) begin
                chk("wrap_pc", inst2_pc, e2);
                chk("wrap_data", inst2_data, memf(e2));
                e2 += 32'd4;
            end
            check_cycle();
            @(negedge clock);
        end
        chk("wrap_progress", e2, 32'hFFFF_FFF8 + 32'(4 * (8 - LAT)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
